// File: rtl/pc_trace_recorder_pkg.sv
// -----------------------------------------------------------------------------
// pc_trace_recorder_pkg
//   Shared definitions for the PC trace recorder: FSM state codes and the
//   default geometry of the capture FIFO and its sequence/overflow counters.
// -----------------------------------------------------------------------------
package pc_trace_recorder_pkg;

  // Default geometry. DEPTH must be a power of two and ADDR_W = log2(DEPTH).
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned SEQ_W_DEF  = 16;

  // Width of the captured CPU words.
  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  // FSM state codes; the encoding is visible on the state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } trc_state_e;

endpackage : pc_trace_recorder_pkg

// File: rtl/pc_trace_recorder_trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
//   First-word-fall-through circular FIFO holding captured trace entries.
//   The head entry is visible combinationally on out_data_o while the FIFO is
//   not empty; once empty, out_data_o holds the most recently popped entry
//   (all zeros until the first pop after reset).
//
// Ports
//   clk_in      in   system clock
//   reset       in   asynchronous active-high reset (clears pointers/holding reg)
//   push_i      in   request to write push_data_i
//   push_data_i in   entry to write
//   pop_i       in   request to drop the head entry (ignored when empty)
//   accept_o    out  push_i was accepted this cycle (not dropped for full)
//   valid_o     out  FIFO not empty
//   out_data_o  out  head entry (or last popped entry when empty)
//   count_o     out  number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 80
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              accept_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W:0]   count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] last_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   rd_ptr_q;

  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              empty;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign wr_idx = wr_ptr_q[ADDR_W-1:0];
  assign rd_idx = rd_ptr_q[ADDR_W-1:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_idx == rd_idx);

  // A pop on a full FIFO frees the head slot in the same edge, so a
  // simultaneous push can land in it without being dropped.
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full || pop_ok);

  always_ff @(posedge clk_in or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_idx];
      end
    end
  end

  // NOTE: storage has no reset; the pointers decide what is valid and the
  // head is only read from the array while the FIFO is non-empty.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

  assign accept_o   = push_ok;
  assign valid_o    = !empty;
  assign out_data_o = empty ? last_q : mem_q[rd_idx];
  assign count_o    = wr_ptr_q - rd_ptr_q;

endmodule : trace_fifo

// File: rtl/pc_trace_recorder.sv
// -----------------------------------------------------------------------------
// pc_trace_recorder
//   Records the retired {pc, inst} stream of a single-cycle CPU into a
//   circular FIFO and drains it over a valid/ready port. An arm/trigger FSM
//   starts capture on the cycle where pc == trig_pc and stops after cap_limit
//   capture attempts (0 = unlimited) or on a stop pulse. Each attempt gets a
//   sequence number; attempts dropped because the FIFO is full still consume
//   a sequence number and bump a saturating overflow counter.
//
// Ports
//   clk_in       in   system clock
//   reset        in   asynchronous active-high reset
//   pc, inst     in   CPU program counter and instruction, sampled every edge
//   arm          in   pulse: IDLE/DONE -> ARMED
//   stop         in   pulse: ARMED/RUN -> DONE (wins over trigger/limit)
//   trig_pc      in   trigger program counter
//   cap_limit    in   capture attempts after trigger, 0 = unlimited
//   out_valid    out  head entry available
//   out_ready    in   consumer accepts head when out_valid & out_ready
//   out_pc       out  head pc
//   out_inst     out  head instruction
//   out_seq      out  head sequence number
//   count        out  entries held, 0..DEPTH
//   overflow_cnt out  dropped attempts, saturating
//   state        out  FSM state code
// -----------------------------------------------------------------------------
module pc_trace_recorder
  import pc_trace_recorder_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned SEQ_W  = SEQ_W_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  input  logic              arm,
  input  logic              stop,
  input  logic [31:0]       trig_pc,
  input  logic [SEQ_W-1:0]  cap_limit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [SEQ_W-1:0]  out_seq,
  output logic [ADDR_W:0]   count,
  output logic [SEQ_W-1:0]  overflow_cnt,
  output logic [1:0]        state
);

  localparam int unsigned DATA_W = PC_W + INST_W + SEQ_W;

  trc_state_e        state_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [SEQ_W-1:0]  seq_d;
  logic [SEQ_W-1:0]  overflow_q;

  logic              trig_hit;
  logic              attempt;
  logic              limit_hit;
  logic              accepted;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] head_data;

  assign trig_hit = (pc == trig_pc);

  // Capture happens on the trigger cycle itself and on every RUN cycle; a
  // stop pulse suppresses the capture of the cycle it arrives in.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    attempt   = 1'b0;
    seq_d     = seq_q + 1'b1;
    limit_hit = 1'b0;
    if (!stop) begin
      attempt = (state_q == ST_RUN) || ((state_q == ST_ARMED) && trig_hit);
    end
    // seq_d is the count of attempts including this one.
    limit_hit = (cap_limit != '0) && (seq_d == cap_limit);
  end

  // FSM and sequence counter.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q <= ST_ARMED;
            seq_q   <= '0;
          end
        end
        ST_ARMED: begin
          if (stop) begin
            state_q <= ST_DONE;
          end else if (trig_hit) begin
            seq_q   <= seq_d;
            state_q <= limit_hit ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_DONE;
          end else begin
            seq_q <= seq_d;
            if (limit_hit) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Re-arming restarts numbering but keeps undrained entries.
          if (arm) begin
            state_q <= ST_ARMED;
            seq_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of attempts the FIFO could not take.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      overflow_q <= '0;
    end else if (attempt && !accepted && (overflow_q != '1)) begin
      overflow_q <= overflow_q + 1'b1;
    end
  end

  assign push_data = {pc, inst, seq_q};

  trace_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_in      (clk_in),
    .reset       (reset),
    .push_i      (attempt),
    .push_data_i (push_data),
    .pop_i       (out_ready),
    .accept_o    (accepted),
    .valid_o     (out_valid),
    .out_data_o  (head_data),
    .count_o     (count)
  );

  assign out_pc       = head_data[DATA_W-1 -: PC_W];
  assign out_inst     = head_data[SEQ_W +: INST_W];
  assign out_seq      = head_data[SEQ_W-1:0];
  assign overflow_cnt = overflow_q;
  assign state        = state_q;

endmodule : pc_trace_recorder
